pcie_tlp_tx_buffer: RTL and testbench
=====================================

PCIE_TLP_TX_BUFFER -- requirements
Module: pcie_tlp_tx_buffer

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, beat width; KEEP_WIDTH, default DATA_WIDTH/8, keep width; USER_WIDTH, default 5, sideband width; DEPTH, default 64, buffer words (power of 2).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 link_up_i  in  1  PHY link up.
REQ-006 fc_initialized_i  in  1  datalink flow-control init done.
REQ-007 s_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  TLP beats from transaction layer; tuser[0]=abort.
REQ-008 s_axis_tready  out  1  beat accepted when tvalid&&tready.
REQ-009 m_axis_tdata/tkeep/tvalid/tlast/tuser  out  same widths  TLP beats to PHY top TLP input.
REQ-010 m_axis_tready  in  1  downstream ready.
REQ-011 pkt_count_o  out  $clog2(DEPTH)+1  committed TLPs held.
REQ-012 drop_o  out  1  one-cycle pulse per dropped TLP.

Function
REQ-013 Store-and-forward: a TLP becomes readable only after its tlast beat is written and committed.
REQ-014 Write FSM states ACCEPT, DROP; reset to ACCEPT.
REQ-015 ACCEPT: each accepted beat written at wr_ptr; on tlast with tuser[0]=0, commit_ptr<=wr_ptr+1 and pkt_count increments.
REQ-016 ACCEPT, tlast with tuser[0]=1: wr_ptr rewinds to commit_ptr, drop_o pulses next cycle.
REQ-017 ACCEPT, beat arrives with buffer full: beat discarded, wr_ptr rewinds to commit_ptr, drop_o pulses, go DROP unless that beat is tlast (then stay ACCEPT).
REQ-018 DROP: s_axis_tready=1, beats discarded; tlast returns to ACCEPT; no further drop_o.
REQ-019 s_axis_tready=1 in both states whenever link_up_i=1; 0 when link_up_i=0.
REQ-020 Read FSM states IDLE, SEND; starts a TLP only when pkt_count>0, link_up_i=1, fc_initialized_i=1.
REQ-021 First beat valid on m_axis 2 cycles after commit when gating already true (1 commit + 1 RAM read).
REQ-022 SEND: standard AXIS; m_axis outputs stable while tvalid&&!tready; tvalid not dropped except REQ-024.
REQ-023 On last beat accepted downstream: pkt_count decrements; back-to-back TLPs allowed without idle cycle.
REQ-024 link_up_i falling (sampled 0): flush next cycle: all pointers equal, pkt_count=0, both FSMs to initial, m_axis_tvalid=0, partial TLPs discarded without drop_o.
REQ-025 Simultaneous commit and read-side decrement: pkt_count unchanged.
REQ-026 Full = wr_ptr-rd_ptr==DEPTH using extra pointer bit; pointers wrap modulo 2*DEPTH.
REQ-027 TLP longer than DEPTH beats: always dropped per REQ-017.

Reset
REQ-028 Reset: s_axis_tready=0 during and 1 cycle after (then per REQ-019), m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, pkt_count_o=0, drop_o=0, all pointers 0.
REQ-029 Reset mid-TLP abandons both sides; no output beats until a full new TLP is committed.

Structure
REQ-030 Pointer-width localparams local; tuser abort bit index TLP_USER_ABORT_BIT belongs in pcie_phy_pkg.
REQ-031 Storage in one sub-module tlp_buf_ram: simple dual-port, registered read, width DATA_WIDTH+KEEP_WIDTH+USER_WIDTH+1.

Verification
REQ-032 Link up, fc init, send 4-beat TLP 0x11..0x14, m_tready=1 -> same 4 beats, tlast on 4th, first out 2 cycles after input tlast, pkt_count 1->0.
REQ-033 fc_initialized_i=0, send 3 TLPs -> no m_tvalid, pkt_count=3; raise fc -> 3 TLPs out in order, back-to-back.
REQ-034 DEPTH=64, 70-beat TLP -> drop_o one pulse, zero output, then 2-beat TLP passes intact.
REQ-035 tuser[0]=1 on tlast of 5-beat TLP -> drop_o pulse, no output, pkt_count stays 0.
REQ-036 m_tready toggling 1/0 every cycle on 8-beat TLP -> data held stable while stalled, 8 beats in order.
REQ-037 link_up_i drop during SEND of 2nd of 3 queued TLPs -> tvalid 0 next cycle, pkt_count 0, no drop_o.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared definitions for the PCIe PHY-side TLP datapath blocks.
package pcie_phy_pkg;

  localparam int TLP_USER_ABORT_BIT = 0;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } tlp_wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } tlp_rd_state_e;

endpackage

// File: rtl/tlp_buf_ram.sv
// Simple dual-port TLP storage with a registered, enable-gated read port.
module tlp_buf_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // The read register only updates on rd_en_i, so it doubles as the held output beat.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pcie_tlp_tx_buffer.sv
// Store-and-forward TLP buffer between the transaction layer and the PHY TLP input.
module pcie_tlp_tx_buffer
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 5,
  parameter int DEPTH      = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      link_up_i,
  input  logic                      fc_initialized_i,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    pkt_count_o,
  output logic                      drop_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  tlp_wr_state_e   wr_state_q, wr_state_d;
  tlp_rd_state_e   rd_state_q, rd_state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            tvalid_q, tvalid_d;
  logic            drop_q, drop_d;
  logic            ready_en_q;

  logic            accept;
  logic            full;
  logic            ram_we;
  logic            ram_re;
  logic            commit;
  logic            rd_done;
  logic            start_ok;
  logic            cur_last;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  assign s_axis_tready = link_up_i && ready_en_q && !rst_i;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign full          = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign wr_word       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign cur_last      = rd_word[0];
  assign start_ok      = (pkt_count_q != '0) && link_up_i && fc_initialized_i;

  tlp_buf_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_word),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_word)
  );

  // Write side: beats land at wr_ptr; only a clean tlast publishes them via commit_ptr.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = 1'b0;
    ram_we       = 1'b0;
    commit       = 1'b0;
    if (accept) begin
      case (wr_state_q)
        WR_ACCEPT: begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            if (!s_axis_tlast) begin
              wr_state_d = WR_DROP;
            end
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              if (s_axis_tuser[TLP_USER_ABORT_BIT]) begin
                wr_ptr_d = commit_ptr_q;
                drop_d   = 1'b1;
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                commit       = 1'b1;
              end
            end
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            wr_state_d = WR_ACCEPT;
          end
        end
        default: wr_state_d = WR_ACCEPT;
      endcase
    end
  end

  // Read side: rd_ptr is the next word to fetch; the presented beat lives in the RAM read register.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    tvalid_d   = tvalid_q;
    ram_re     = 1'b0;
    rd_done    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (start_ok) begin
          rd_state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (!tvalid_q) begin
          ram_re = 1'b1;
        end else if (m_axis_tready) begin
          if (!cur_last) begin
            ram_re = 1'b1;
          end else begin
            rd_done = 1'b1;
            if ((pkt_count_q > PW'(1)) && link_up_i && fc_initialized_i) begin
              ram_re = 1'b1;
            end else begin
              tvalid_d   = 1'b0;
              rd_state_d = RD_IDLE;
            end
          end
        end
        if (ram_re) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          tvalid_d = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (commit && !rd_done) begin
      pkt_count_d = pkt_count_q + PW'(1);
    end else if (!commit && rd_done) begin
      pkt_count_d = pkt_count_q - PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q   <= WR_ACCEPT;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      tvalid_q     <= 1'b0;
      drop_q       <= 1'b0;
      ready_en_q   <= 1'b0;
    end else if (!link_up_i) begin
      // Link loss discards everything, including partial TLPs, silently.
      wr_state_q   <= WR_ACCEPT;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      tvalid_q     <= 1'b0;
      drop_q       <= 1'b0;
      ready_en_q   <= 1'b1;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      tvalid_q     <= tvalid_d;
      drop_q       <= drop_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Payload is masked while idle so the bus reads zero out of reset.
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tvalid_q ? rd_word[WORD_W-1 -: DATA_WIDTH] : '0;
  assign m_axis_tkeep  = tvalid_q ? rd_word[USER_WIDTH+1 +: KEEP_WIDTH] : '0;
  assign m_axis_tuser  = tvalid_q ? rd_word[1 +: USER_WIDTH] : '0;
  assign m_axis_tlast  = tvalid_q && cur_last;
  assign pkt_count_o   = pkt_count_q;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_pcie_tlp_tx_buffer.sv
// Scoreboard bench for pcie_tlp_tx_buffer: directed TLPs in, monitor checks beats out.
module tb_pcie_tlp_tx_buffer;

  typedef logic [42:0] beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up;
  logic        fc_init;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic [4:0]  s_tuser;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic [4:0]  m_tuser;
  logic        m_tready;
  logic [6:0]  pkt_count;
  logic        drop;

  beat_t exp_q[$];
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    drop_cnt   = 0;
  int    beats_seen = 0;
  logic  seen_valid = 1'b0;
  logic  hold_prev  = 1'b0;
  beat_t hold_word  = '0;

  always #5 clk = ~clk;

  pcie_tlp_tx_buffer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .link_up_i        (link_up),
    .fc_initialized_i (fc_init),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tuser     (s_tuser),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tuser     (m_tuser),
    .m_axis_tready    (m_tready),
    .pkt_count_o      (pkt_count),
    .drop_o           (drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %-18s got 0x%0h ok", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, no such event expected", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [4:0] user);
    int guard;
    guard    = 0;
    s_tdata  = d;
    s_tkeep  = 4'hF;
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) fail_event("tready_timeout", 64'(guard));
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic send_tlp(input logic [31:0] base, input int n, input logic abort, input int n_exp);
    logic [31:0] iv;
    logic        last;
    logic [4:0]  user;
    for (int i = 0; i < n; i++) begin
      iv   = 32'(i);
      last = (i == n - 1);
      user = {iv[3:0], last && abort};
      if (i < n_exp) exp_q.push_back({base + iv, 4'hF, user, last});
      send_beat(base + iv, last, user);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_tvalid) && g < max_cycles) begin
      tick();
      g++;
    end
    if (g >= max_cycles) fail_event("drain_timeout", 64'(exp_q.size()));
    check("pkt_count_drained", 64'(pkt_count), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    beat_t act;
    act = {m_tdata, m_tkeep, m_tuser, m_tlast};
    if (!rst && link_up && hold_prev) begin
      check("stall_valid", 64'(m_tvalid), 64'd1);
      check("stall_data", 64'(act), 64'(hold_word));
    end
    if (m_tvalid) seen_valid = 1'b1;
    if (m_tvalid && m_tready && !rst) begin
      if (exp_q.size() == 0) fail_event("unexpected_beat", 64'(act));
      else check("beat", 64'(act), 64'(exp_q.pop_front()));
      beats_seen++;
    end
    hold_prev = m_tvalid && !m_tready;
    hold_word = act;
    if (drop) drop_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int d0;
    int b0;
    int g;
    int run;
    rst = 1'b1; link_up = 1'b1; fc_init = 1'b1; m_tready = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;

    // Reset values
    repeat (3) tick();
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    rst = 1'b0;
    check("tready_post_rst", 64'(s_tready), 64'd0);
    tick();
    check("tready_up", 64'(s_tready), 64'd1);

    // 4-beat TLP with latency check
    send_tlp(32'h11, 4, 1'b0, 4);
    check("pkt_count_commit", 64'(pkt_count), 64'd1);
    check("lat_cycle0", 64'(m_tvalid), 64'd0);
    tick();
    check("lat_cycle1", 64'(m_tvalid), 64'd0);
    tick();
    check("lat_cycle2", 64'(m_tvalid), 64'd1);
    wait_drain(50);

    // Gated by fc, then back-to-back release
    fc_init = 1'b0;
    seen_valid = 1'b0;
    send_tlp(32'h100, 2, 1'b0, 2);
    send_tlp(32'h200, 3, 1'b0, 3);
    send_tlp(32'h300, 1, 1'b0, 1);
    repeat (5) tick();
    check("fc_gate_count", 64'(pkt_count), 64'd3);
    check("fc_gate_novalid", 64'(seen_valid), 64'd0);
    fc_init = 1'b1;
    g = 0;
    while (!m_tvalid && g < 10) begin tick(); g++; end
    run = 0;
    while (m_tvalid && run < 50) begin run++; tick(); end
    check("back_to_back_run", 64'(run), 64'd6);
    wait_drain(50);

    // Aborted TLP
    d0 = drop_cnt;
    seen_valid = 1'b0;
    send_tlp(32'h500, 5, 1'b1, 0);
    repeat (3) tick();
    check("abort_drop", 64'(drop_cnt - d0), 64'd1);
    check("abort_count", 64'(pkt_count), 64'd0);
    repeat (5) tick();
    check("abort_novalid", 64'(seen_valid), 64'd0);

    // Oversized TLP, then a short one
    d0 = drop_cnt;
    seen_valid = 1'b0;
    send_tlp(32'h1000, 70, 1'b0, 0);
    repeat (3) tick();
    check("oversize_drop", 64'(drop_cnt - d0), 64'd1);
    check("oversize_count", 64'(pkt_count), 64'd0);
    check("oversize_novalid", 64'(seen_valid), 64'd0);
    send_tlp(32'h2000, 2, 1'b0, 2);
    wait_drain(50);

    // Backpressure toggling
    m_tready = 1'b0;
    send_tlp(32'h3000, 8, 1'b0, 8);
    repeat (40) begin
      m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    wait_drain(50);

    // Link drop during the second of three queued TLPs
    fc_init = 1'b0;
    send_tlp(32'h4000, 4, 1'b0, 4);
    send_tlp(32'h4100, 4, 1'b0, 2);
    send_tlp(32'h4200, 4, 1'b0, 0);
    b0 = beats_seen;
    d0 = drop_cnt;
    fc_init = 1'b1;
    g = 0;
    while ((beats_seen - b0) < 5 && g < 100) begin tick(); g++; end
    if (g >= 100) fail_event("link_wait_timeout", 64'(beats_seen - b0));
    link_up = 1'b0;
    tick();
    check("flush_tvalid", 64'(m_tvalid), 64'd0);
    check("flush_count", 64'(pkt_count), 64'd0);
    tick();
    check("flush_nodrop", 64'(drop_cnt - d0), 64'd0);
    link_up = 1'b1;
    repeat (3) tick();
    check("flush_queue", 64'(exp_q.size()), 64'd0);
    send_tlp(32'h5000, 2, 1'b0, 2);
    wait_drain(50);

    // Reset mid-TLP abandons the partial packet
    send_beat(32'h6000, 1'b0, 5'd0);
    send_beat(32'h6001, 1'b0, 5'd0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("midrst_count", 64'(pkt_count), 64'd0);
    send_tlp(32'h7000, 3, 1'b0, 3);
    wait_drain(50);

    repeat (5) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
